// File: rtl/key_conditioner_pkg.sv
// Shared constants and helpers for the push-button conditioner.
package key_pkg;
   localparam int NUM_BTN_DEF     = 3;
   localparam int DEBOUNCE_DEF    = 500000;
   localparam int CODE_W          = 2;

   typedef logic [CODE_W-1:0] code_t;

   // Width that holds 0..n-1; never narrower than one bit.
   function automatic int clog2_w(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/key_conditioner_if.sv
// Button inputs and conditioned outputs of the key conditioner.
interface key_conditioner_if
   import key_pkg::*;
#(
   parameter int NUM_BTN = NUM_BTN_DEF
) ();
   logic [NUM_BTN-1:0] key_n;
   logic [NUM_BTN-1:0] held;
   logic [NUM_BTN-1:0] press;
   // Release pulse; "release" itself is a reserved word.
   logic [NUM_BTN-1:0] rel;
   logic               evt_valid;
   code_t              evt_code;

   modport master (
      input  key_n,
      output held, press, rel, evt_valid, evt_code
   );

   modport slave (
      output key_n,
      input  held, press, rel, evt_valid, evt_code
   );
endinterface

// File: rtl/key_conditioner_debounce_cell.sv
// Single-button synchroniser, debounce counter, held level and edge pulses.
module debounce_cell
   import key_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic held,
   output logic press,
   output logic rel,
   output logic accept_rise
);
   localparam int               CNT_W  = clog2_w(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CNT_W-1:0]       cnt;
   logic                   s;
   logic                   at_tc;

   assign s           = ~sync[SYNC_STAGES-1];
   assign at_tc       = (s != held) && (cnt == CNT_TC);
   // Exposed so the serialiser can queue the press in the same edge as held rises.
   assign accept_rise = at_tc && s;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync  <= '1;
         cnt   <= '0;
         held  <= 1'b0;
         press <= 1'b0;
         rel   <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], key_n};
         press <= accept_rise;
         rel   <= at_tc && !s;
         if (s == held) begin
            cnt <= '0;
         end else if (cnt == CNT_TC) begin
            held <= s;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: rtl/key_conditioner.sv
// Debounces NUM_BTN active-low buttons and serialises presses into one event stream.
module key_conditioner
   import key_pkg::*;
#(
   parameter int NUM_BTN         = NUM_BTN_DEF,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
   input logic                clk,
   input logic                rst,
   key_conditioner_if.master  kif
);
   logic [NUM_BTN-1:0] held_v;
   logic [NUM_BTN-1:0] press_v;
   logic [NUM_BTN-1:0] rel_v;
   logic [NUM_BTN-1:0] accept_v;
   logic [NUM_BTN-1:0] pending;
   logic [NUM_BTN-1:0] grant;
   code_t              grant_idx;
   logic               evt_valid_r;
   code_t              evt_code_r;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
      debounce_cell #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_cell (
         .clk         (clk),
         .rst         (rst),
         .key_n       (kif.key_n[i]),
         .held        (held_v[i]),
         .press       (press_v[i]),
         .rel         (rel_v[i]),
         .accept_rise (accept_v[i])
      );
   end

   // Lowest set bit of pending wins.
   always_comb begin
      grant     = pending & (~pending + NUM_BTN'(1));
      grant_idx = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (grant[i]) grant_idx = CODE_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending     <= '0;
         evt_valid_r <= 1'b0;
         evt_code_r  <= '0;
      end else begin
         pending     <= (pending & ~grant) | accept_v;
         evt_valid_r <= |grant;
         evt_code_r  <= grant_idx;
      end
   end

   assign kif.held      = held_v;
   assign kif.press     = press_v;
   assign kif.rel       = rel_v;
   assign kif.evt_valid = evt_valid_r;
   assign kif.evt_code  = evt_code_r;
endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with a short debounce window.
module tb_key_conditioner;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic [2:0] press;
      logic [2:0] rel;
      int         cyc;
   } edge_t;

   typedef struct {
      logic [1:0] code;
      int         cyc;
   } evt_t;

   edge_t edgeq[$];
   evt_t  evq[$];

   key_conditioner_if #(.NUM_BTN(3)) kif ();

   key_conditioner #(
      .NUM_BTN         (3),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kif (kif.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic exp_edge(input logic [2:0] p, input logic [2:0] r, input int c);
      edge_t e;
      e.press = p; e.rel = r; e.cyc = c;
      edgeq.push_back(e);
   endtask

   task automatic exp_evt(input logic [1:0] code, input int c);
      evt_t e;
      e.code = code; e.cyc = c;
      evq.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_held(input string name, input logic [2:0] want);
      checks++;
      if (kif.held !== want) begin
         errors++;
         $display("FAIL %s held=%b want=%b cyc=%0d", name, kif.held, want, cyc);
      end
   endtask

   // Monitor: every pulse the DUT shows must match the head of its queue.
   always @(negedge clk) begin
      edge_t ee;
      evt_t  ev;
      if ((kif.press | kif.rel) != 3'b000) begin
         checks++;
         if (edgeq.size() == 0) begin
            errors++;
            $display("FAIL edge_unexpected press=%b rel=%b cyc=%0d", kif.press, kif.rel, cyc);
         end else begin
            ee = edgeq.pop_front();
            if (kif.press !== ee.press || kif.rel !== ee.rel || cyc != ee.cyc) begin
               errors++;
               $display("FAIL edge press=%b rel=%b cyc=%0d want press=%b rel=%b cyc=%0d",
                        kif.press, kif.rel, cyc, ee.press, ee.rel, ee.cyc);
            end
         end
      end
      if (kif.evt_valid === 1'b1) begin
         checks++;
         if (evq.size() == 0) begin
            errors++;
            $display("FAIL evt_unexpected code=%0d cyc=%0d", kif.evt_code, cyc);
         end else begin
            ev = evq.pop_front();
            if (kif.evt_code !== ev.code || cyc != ev.cyc) begin
               errors++;
               $display("FAIL evt code=%0d cyc=%0d want code=%0d cyc=%0d",
                        kif.evt_code, cyc, ev.code, ev.cyc);
            end
         end
      end
   end

   initial begin
      int n;
      kif.key_n = 3'b000;
      rst = 1'b1;

      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({kif.held, kif.press, kif.rel, kif.evt_valid, kif.evt_code} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs held=%b press=%b rel=%b vld=%b code=%0d want all 0",
                     kif.held, kif.press, kif.rel, kif.evt_valid, kif.evt_code);
         end
      end

      // All buttons already pressed when reset drops.
      n = cyc;
      rst = 1'b0;
      exp_edge(3'b111, 3'b000, n + 10);
      exp_evt(2'd0, n + 11);
      exp_evt(2'd1, n + 12);
      exp_evt(2'd2, n + 13);
      wait_cyc(15);
      check_held("held_after_reset", 3'b111);

      n = cyc;
      kif.key_n = 3'b111;
      exp_edge(3'b000, 3'b111, n + 10);
      wait_cyc(15);
      check_held("held_all_released", 3'b000);

      // Clean press of button 1 with a long hold.
      n = cyc;
      kif.key_n = 3'b101;
      exp_edge(3'b010, 3'b000, n + 10);
      exp_evt(2'd1, n + 11);
      wait_cyc(200);
      check_held("held_clean", 3'b010);
      n = cyc;
      kif.key_n = 3'b111;
      exp_edge(3'b000, 3'b010, n + 10);
      wait_cyc(15);

      // Bounce on button 0: 5 low, 2 high, then steady low.
      kif.key_n = 3'b110;
      wait_cyc(5);
      kif.key_n = 3'b111;
      wait_cyc(2);
      n = cyc;
      kif.key_n = 3'b110;
      exp_edge(3'b001, 3'b000, n + 10);
      exp_evt(2'd0, n + 11);
      wait_cyc(15);
      check_held("held_bounce", 3'b001);
      n = cyc;
      kif.key_n = 3'b111;
      exp_edge(3'b000, 3'b001, n + 10);
      wait_cyc(15);

      // Press then release of button 2; the release must not raise an event.
      n = cyc;
      kif.key_n = 3'b011;
      exp_edge(3'b100, 3'b000, n + 10);
      exp_evt(2'd2, n + 11);
      wait_cyc(15);
      check_held("held_b2", 3'b100);
      n = cyc;
      kif.key_n = 3'b111;
      exp_edge(3'b000, 3'b100, n + 10);
      wait_cyc(15);
      check_held("held_b2_released", 3'b000);

      // Simultaneous press of buttons 0 and 2.
      n = cyc;
      kif.key_n = 3'b010;
      exp_edge(3'b101, 3'b000, n + 10);
      exp_evt(2'd0, n + 11);
      exp_evt(2'd2, n + 12);
      wait_cyc(15);
      check_held("held_simul", 3'b101);
      n = cyc;
      kif.key_n = 3'b111;
      exp_edge(3'b000, 3'b101, n + 10);
      wait_cyc(15);

      // Reset while button 1 is at count 5.
      kif.key_n = 3'b101;
      wait_cyc(7);
      rst = 1'b1;
      wait_cyc(1);
      check_held("held_in_reset", 3'b000);
      n = cyc;
      rst = 1'b0;
      exp_edge(3'b010, 3'b000, n + 10);
      exp_evt(2'd1, n + 11);
      wait_cyc(15);
      check_held("held_after_midreset", 3'b010);
      n = cyc;
      kif.key_n = 3'b111;
      exp_edge(3'b000, 3'b010, n + 10);
      wait_cyc(20);

      checks++;
      if (edgeq.size() != 0) begin
         errors++;
         $display("FAIL edge_missing pending=%0d want 0", edgeq.size());
      end
      checks++;
      if (evq.size() != 0) begin
         errors++;
         $display("FAIL evt_missing pending=%0d want 0", evq.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Upstream conditioning stage for the key checker.
- Takes the raw active-low KEY push-buttons, synchronises and debounces each one, and produces clean one-cycle press/release pulses plus a debounced level.
- Serialises presses into a single event stream (valid + button code), so the key checker sees exactly one event per physical press, in order, with no bounce and no metastability.

Parameters:
- NUM_BTN, 3, number of push-buttons conditioned (1..4).
- SYNC_STAGES, 2, depth of the input synchroniser flop chain (min 2).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz; min 2).
- CNT_W, clog2(DEBOUNCE_CYCLES), debounce counter width (derived, not overridden).

Ports:
- clk  in  1  system clock (CLK_50 domain).
- rst  in  1  synchronous, active-high reset.
- key_n  in  NUM_BTN  raw asynchronous buttons; 0 = pressed.
- held  out  NUM_BTN  debounced level; 1 = pressed.
- press  out  NUM_BTN  one-cycle pulse on debounced press.
- release  out  NUM_BTN  one-cycle pulse on debounced release.
- evt_valid  out  1  one-cycle pulse: one queued press is being reported.
- evt_code  out  2  index of the reported button; valid only with evt_valid.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - Synchroniser flops = 1 (released).
  - held = 0, press = 0, release = 0, evt_valid = 0, evt_code = 0.
  - Counters = 0, pending = 0.
- Reset mid-operation: all of the above are restored on the next edge; any partially debounced or pending press is discarded.
- Synchroniser:
  - Per bit, SYNC_STAGES flops.
  - s[i] = ~(last stage), so 1 = pressed.
- Debounce (per button, independent):
  - If s[i] == held[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: held[i] <= s[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Any glitch back to held[i] before the terminal count restarts the count from 0.
  - Result: a level change is accepted after exactly DEBOUNCE_CYCLES consecutive disagreeing samples.
- Edge pulses:
  - press[i] is registered and high for exactly one cycle, in the same cycle held[i] rises.
  - release[i] is high for exactly one cycle, in the same cycle held[i] falls.
  - Latency from the first clock edge sampling the new key_n level to the press pulse = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Event serialiser:
  - State: pending[NUM_BTN-1:0].
  - grant = lowest-index set bit of pending (one-hot, 0 if none).
  - pending <= (pending & ~grant) | press.
  - If grant != 0: next cycle evt_valid = 1 and evt_code = index(grant).
  - Simultaneous presses of different buttons are reported on consecutive cycles, lowest index first; none are dropped.
  - A new press of a button whose grant is being issued in the same cycle re-sets its pending bit, producing a second event.
  - A repeated press of an already-pending, not-yet-granted button merges; this is unreachable for DEBOUNCE_CYCLES >= NUM_BTN.
  - Event latency = press + 1 cycle minimum, plus 1 cycle per lower-index pending button.
- No backpressure: the consumer must accept an event every cycle.
- Long holds produce no repeats; release produces no event.

Decomposition:
- Shared package (key_pkg): NUM_BTN default, DEBOUNCE_CYCLES default, the clog2 width function, and the evt_code width constant (2).
- One sub-module: debounce_cell. It contains the synchroniser, counter, held register and press/release pulses for a single bit, and is instantiated NUM_BTN times by generate.
- The serialiser/priority encoder lives in key_conditioner.

Test Plan (DEBOUNCE_CYCLES=8, SYNC_STAGES=2, NUM_BTN=3):
- Reset: rst high for 3 cycles with key_n=3'b000 -> all outputs 0 during reset. After release, held becomes 3'b111 exactly 10 cycles later, with press=3'b111 for 1 cycle. Events follow: codes 0,1,2 on 3 consecutive cycles.
- Clean press: key_n[1] driven 1->0 and held -> press[1] pulses at cycle 10. evt_valid=1 with evt_code=1 at cycle 11. No further events during a 200-cycle hold.
- Bounce rejection: key_n[0] toggles low for 5 cycles, high for 2, then low steady -> the counter restarts. press[0] occurs 10 cycles after the final falling edge, and exactly one event is reported.
- Release: after a held press, key_n[2] goes 0->1 -> release[2] pulses once at cycle 10. held[2]=0, and no event is produced.
- Simultaneous press: key_n 3'b111->3'b010 -> press=3'b101 in one cycle. Events follow: code 0, then code 2, on the next two cycles.
- Reset mid-debounce: rst pulsed at count 5 of a key_n[1] press with the key held -> no press or event from the aborted count. After reset, the count restarts and press[1] occurs 10 cycles after rst falls.
